pico_decoder: RTL and testbench
===============================

Name: pico_decoder

Overview:
- Instruction decode and control sequencer for picoMIPS.
- Produces the ALU function code and operand/writeback selects that drive the ALU, plus register write enable and PC increment.
- Implements the switch-handshake instructions (WAITH/WAITL), which stall the PC until a debounced SW8 level is seen.
- Sits between program memory output and the datapath (ALU, register file, PC).

Parameters:
I_W, 24, instruction width; opcode is instr[I_W-1:I_W-3]
DEB, 4, consecutive synchronised-SW8 cycles at the target level required to release a wait (DEB >= 1)
CNT_W, 3, debounce counter width; must satisfy 2^CNT_W > DEB

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
instr  input  I_W  current instruction from program memory
sw8  input  1  raw handshake switch, asynchronous to clk
ALUfunc  output  2  ALU function code, using the shared ALU code definitions RA/RB/RADD/RMUL
imm_sel  output  1  1 = ALU operand b from instruction immediate, 0 = from register rs
in_sel  output  1  1 = ALU operand b from switch inputs
reg_we  output  1  register file write enable for rd
pc_incr  output  1  1 = PC advances at next edge, 0 = PC holds
waiting  output  1  1 while in WAIT state

Behaviour:
- Reset is synchronous and active-high; one clock; all flops update on the rising clk edge.
- SW8 synchroniser: 2-flop chain sw_s1 -> sw_s2; sw_sync = sw_s2; both flops reset to 0.
- State machine has two states, RUN and WAIT. It also holds cnt (CNT_W bits) and tgt (1 bit, target level).
- Reset values: state = RUN, cnt = 0, tgt = 0, sync flops = 0.
- Outputs are combinational from the current state and instr. While reset is asserted, all outputs are forced to 0 and ALUfunc = RA.
- Opcode decode in RUN (ALUfunc, imm_sel, in_sel, reg_we, pc_incr):
  - 000 NOP: RA, 0, 0, 0, 1
  - 001 ADD: RADD, 0, 0, 1, 1
  - 010 ADDI: RADD, 1, 0, 1, 1
  - 011 MUL: RMUL, 0, 0, 1, 1. The ALU returns the Q1.7 product bits [14:7].
  - 100 MULI: RMUL, 1, 0, 1, 1
  - 101 IN: RB, 0, 1, 1, 1
  - 110 WAITH: RA, 0, 0, 0, 0. Next state WAIT, tgt <= 1, cnt <= 0.
  - 111 WAITL: RA, 0, 0, 0, 0. Next state WAIT, tgt <= 0, cnt <= 0.
- WAIT state:
  - Outputs: ALUfunc = RA, imm_sel = in_sel = reg_we = 0, waiting = 1.
  - If sw_sync != tgt: cnt <= 0, pc_incr = 0.
  - If sw_sync == tgt and cnt < DEB-1: cnt <= cnt+1, pc_incr = 0.
  - If sw_sync == tgt and cnt == DEB-1: pc_incr = 1 for this cycle, then state <= RUN, cnt <= 0.
  - The instr input is ignored while in WAIT; the PC is held, so instr stays stable anyway.
- Latency:
  - A wait releases no earlier than DEB cycles after entering WAIT, plus 2 cycles of synchroniser delay after the raw sw8 edge.
  - If sw8 already sat at the target level for 2 or more cycles before the wait instruction, the release pulse comes exactly DEB cycles after WAIT entry.
- A glitch (sw_sync leaving tgt for one cycle) restarts the count from 0.
- DEB = 1: release on the first WAIT cycle in which sw_sync == tgt.
- Reset asserted mid-WAIT: next state RUN, cnt = 0, sync flops cleared; no pc_incr pulse during reset.
- Back-to-back WAITH then WAITL: each requires its own full debounce. The RUN cycle between them decodes the second instruction normally.
- cnt never exceeds DEB-1; it does not wrap.

Test Plan:
- Reset held 2 cycles with instr = ADD: all outputs 0, ALUfunc = RA. After release: ALUfunc = RADD, reg_we = 1, pc_incr = 1, waiting = 0.
- Sweep all 8 opcodes in RUN, one per cycle: outputs match the decode list. MULI gives RMUL with imm_sel = 1; IN gives RB with in_sel = 1.
- WAITH with sw8 = 0 for 10 cycles, then sw8 = 1 held: waiting = 1 throughout and pc_incr = 0. pc_incr pulses exactly once, 2 + DEB (= 6) cycles after the sw8 rise; state then returns to RUN.
- WAITH with sw8 = 1 pattern 1,1,0,1,1,1,1 (sync-delayed): cnt resets on the 0. Release only after 4 consecutive synced 1s.
- WAITL entered with sw8 = 0 stable: release after exactly 4 WAIT cycles. Then WAITH with sw8 still 0: stays waiting indefinitely (check 50 cycles).
- Reset pulsed at WAIT cycle 2 of 4: next cycle state = RUN, waiting = 0, cnt = 0. No pc_incr pulse during or immediately after reset.

Source files
------------

// File: rtl/pico_decoder_if.sv
// Bus between program memory / datapath (master) and the picoMIPS decoder (slave).
interface pico_decoder_if #(
  parameter int I_W = 24
);
  logic [I_W-1:0] instr;
  logic           sw8;
  logic [1:0]     ALUfunc;
  logic           imm_sel;
  logic           in_sel;
  logic           reg_we;
  logic           pc_incr;
  logic           waiting;

  modport master (
    output instr, sw8,
    input  ALUfunc, imm_sel, in_sel, reg_we, pc_incr, waiting
  );

  modport slave (
    input  instr, sw8,
    output ALUfunc, imm_sel, in_sel, reg_we, pc_incr, waiting
  );
endinterface

// File: rtl/pico_decoder.sv
// picoMIPS instruction decoder with WAITH/WAITL switch handshake.
// Stalls the PC until the synchronised SW8 level has matched the target for DEB cycles.
module pico_decoder #(
  parameter int I_W   = 24,
  parameter int DEB   = 4,
  parameter int CNT_W = 3
) (
  input  logic          clk,
  input  logic          reset,
  pico_decoder_if.slave bus
);

  // state | meaning
  // RUN   | decode instr each cycle, PC advances except on WAITH/WAITL
  // WAIT  | PC held; debounce sw_sync against tgt, release on DEB matches
  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam logic [1:0] RA   = 2'b00;
  localparam logic [1:0] RB   = 2'b01;
  localparam logic [1:0] RADD = 2'b10;
  localparam logic [1:0] RMUL = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgt_q, tgt_d;
  logic             sw_s1_q, sw_s2_q;
  logic             sw_sync;
  logic [2:0]       opcode;
  logic             release_hit;

  assign opcode      = bus.instr[I_W-1 -: 3];
  assign sw_sync     = sw_s2_q;
  assign release_hit = (sw_sync == tgt_q) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      sw_s1_q <= 1'b0;
      sw_s2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      sw_s1_q <= bus.sw8;
      sw_s2_q <= sw_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_RUN: begin
        // 110 = WAITH (wait for 1), 111 = WAITL (wait for 0)
        if (opcode[2:1] == 2'b11) begin
          state_d = S_WAIT;
          tgt_d   = ~opcode[0];
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (sw_sync != tgt_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    bus.ALUfunc = RA;
    bus.imm_sel = 1'b0;
    bus.in_sel  = 1'b0;
    bus.reg_we  = 1'b0;
    bus.pc_incr = 1'b0;
    bus.waiting = 1'b0;
    if (!reset) begin
      case (state_q)
        S_RUN: begin
          case (opcode)
            3'b000: bus.pc_incr = 1'b1;
            3'b001: begin
              bus.ALUfunc = RADD;
              bus.reg_we  = 1'b1;
              bus.pc_incr = 1'b1;
            end
            3'b010: begin
              bus.ALUfunc = RADD;
              bus.imm_sel = 1'b1;
              bus.reg_we  = 1'b1;
              bus.pc_incr = 1'b1;
            end
            3'b011: begin
              bus.ALUfunc = RMUL;
              bus.reg_we  = 1'b1;
              bus.pc_incr = 1'b1;
            end
            3'b100: begin
              bus.ALUfunc = RMUL;
              bus.imm_sel = 1'b1;
              bus.reg_we  = 1'b1;
              bus.pc_incr = 1'b1;
            end
            3'b101: begin
              bus.ALUfunc = RB;
              bus.in_sel  = 1'b1;
              bus.reg_we  = 1'b1;
              bus.pc_incr = 1'b1;
            end
            default: ;
          endcase
        end
        S_WAIT: begin
          bus.waiting = 1'b1;
          bus.pc_incr = release_hit;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pico_decoder.sv
// Self-checking bench for pico_decoder: opcode table sweep plus hand-timed wait sequences.
module tb_pico_decoder;

  localparam int I_W = 24;

  localparam logic [1:0] RA   = 2'b00;
  localparam logic [1:0] RB   = 2'b01;
  localparam logic [1:0] RADD = 2'b10;
  localparam logic [1:0] RMUL = 2'b11;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_ADDI  = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_MULI  = 3'b100;
  localparam logic [2:0] OP_IN    = 3'b101;
  localparam logic [2:0] OP_WAITH = 3'b110;
  localparam logic [2:0] OP_WAITL = 3'b111;

  // packed outputs: {ALUfunc, imm_sel, in_sel, reg_we, pc_incr, waiting}
  localparam logic [6:0] E_ZERO = 7'b00_0_0_0_0_0;
  localparam logic [6:0] E_NOP  = 7'b00_0_0_0_1_0;
  localparam logic [6:0] E_WAIT = 7'b00_0_0_0_0_1;
  localparam logic [6:0] E_REL  = 7'b00_0_0_0_1_1;
  localparam logic [6:0] E_ADD  = {RADD, 5'b0_0_1_1_0};
  localparam logic [6:0] E_ADDI = {RADD, 5'b1_0_1_1_0};
  localparam logic [6:0] E_MUL  = {RMUL, 5'b0_0_1_1_0};
  localparam logic [6:0] E_MULI = {RMUL, 5'b1_0_1_1_0};
  localparam logic [6:0] E_IN   = {RB,   5'b0_1_1_1_0};

  typedef logic [I_W-4:0] rnd_t;

  typedef struct {
    logic [2:0] op;
    logic [6:0] exp;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [6:0] exp_q[$];
  vec_t vt[8];

  always #5 clk = ~clk;

  pico_decoder_if #(.I_W(I_W)) bus ();

  pico_decoder #(.I_W(I_W), .DEB(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // One clock cycle: drive inputs just after the edge, record the expectation,
  // compare at the falling edge, then move to just after the next rising edge.
  task automatic step(input logic rst, input logic [2:0] op, input logic sw,
                      input logic [6:0] exp, input string name);
    logic [6:0] got;
    logic [6:0] want;
    reset     = rst;
    bus.sw8   = sw;
    bus.instr = {op, rnd_t'($urandom)};
    exp_q.push_back(exp);
    @(negedge clk);
    got  = {bus.ALUfunc, bus.imm_sel, bus.in_sel, bus.reg_we, bus.pc_incr, bus.waiting};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t: got=%b want=%b", name, $time, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{OP_NOP,   E_NOP};
    vt[1] = '{OP_ADD,   E_ADD};
    vt[2] = '{OP_ADDI,  E_ADDI};
    vt[3] = '{OP_MUL,   E_MUL};
    vt[4] = '{OP_MULI,  E_MULI};
    vt[5] = '{OP_IN,    E_IN};
    vt[6] = '{OP_WAITH, E_ZERO};
    vt[7] = '{OP_WAITL, E_ZERO};

    bus.instr = '0;
    bus.sw8   = 1'b0;
    @(posedge clk);
    #1;

    step(1'b1, OP_ADD, 1'b0, E_ZERO, "reset_hold");
    step(1'b1, OP_ADD, 1'b0, E_ZERO, "reset_hold");
    step(1'b0, OP_ADD, 1'b0, E_ADD,  "after_reset");

    // Wait opcodes leave RUN, so each is followed by a reset cycle.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, vt[i].op, 1'b0, vt[i].exp, "sweep");
      if (vt[i].op[2:1] == 2'b11)
        step(1'b1, OP_NOP, 1'b0, E_ZERO, "sweep_reset");
    end

    // WAITH, sw8 low for 10 cycles, then rises; PC advances on the 6th edge after the rise.
    step(1'b0, OP_WAITH, 1'b0, E_ZERO, "waith_enter");
    for (int i = 0; i < 10; i++) step(1'b0, OP_WAITH, 1'b0, E_WAIT, "waith_low");
    for (int i = 0; i < 6; i++)
      step(1'b0, OP_WAITH, 1'b1, (i == 5) ? E_REL : E_WAIT, "waith_rise");
    step(1'b0, OP_NOP, 1'b1, E_NOP, "waith_back_run");

    // Glitch 1,1,0,1,1,1,1 restarts the debounce count.
    step(1'b0, OP_NOP, 1'b0, E_NOP, "pre_glitch");
    step(1'b0, OP_NOP, 1'b0, E_NOP, "pre_glitch");
    step(1'b0, OP_WAITH, 1'b0, E_ZERO, "glitch_enter");
    begin
      logic [6:0] pat;
      pat = 7'b1101111;
      for (int k = 0; k < 9; k++)
        step(1'b0, OP_WAITH, (k < 7) ? pat[6-k] : 1'b1,
             (k == 8) ? E_REL : E_WAIT, "glitch_wait");
    end
    step(1'b0, OP_NOP, 1'b1, E_NOP, "glitch_back_run");

    // WAITL with sw8 already low: release on the 4th WAIT cycle.
    step(1'b0, OP_NOP, 1'b0, E_NOP, "pre_waitl");
    step(1'b0, OP_NOP, 1'b0, E_NOP, "pre_waitl");
    step(1'b0, OP_WAITL, 1'b0, E_ZERO, "waitl_enter");
    for (int k = 0; k < 4; k++)
      step(1'b0, OP_WAITL, 1'b0, (k == 3) ? E_REL : E_WAIT, "waitl_wait");

    // WAITH with sw8 still low never releases.
    step(1'b0, OP_WAITH, 1'b0, E_ZERO, "waith_stuck_enter");
    for (int k = 0; k < 50; k++) step(1'b0, OP_WAITH, 1'b0, E_WAIT, "waith_stuck");

    // Reset at WAIT cycle 2 of 4: back to RUN with count and synchroniser cleared.
    step(1'b1, OP_NOP, 1'b1, E_ZERO, "mid_reset_pre");
    step(1'b0, OP_NOP, 1'b1, E_NOP, "mid_pre");
    step(1'b0, OP_NOP, 1'b1, E_NOP, "mid_pre");
    step(1'b0, OP_WAITH, 1'b1, E_ZERO, "mid_enter");
    step(1'b0, OP_WAITH, 1'b1, E_WAIT, "mid_w1");
    step(1'b1, OP_WAITH, 1'b1, E_ZERO, "mid_reset");
    step(1'b0, OP_WAITH, 1'b1, E_ZERO, "mid_after_reset");
    for (int k = 0; k < 5; k++)
      step(1'b0, OP_WAITH, 1'b1, (k == 4) ? E_REL : E_WAIT, "mid_rewait");

    // Back-to-back: WAITL right after the WAITH release needs its own debounce.
    step(1'b0, OP_WAITL, 1'b1, E_ZERO, "b2b_enter");
    for (int k = 0; k < 6; k++) step(1'b0, OP_WAITL, 1'b1, E_WAIT, "b2b_high");
    for (int k = 0; k < 6; k++)
      step(1'b0, OP_WAITL, 1'b0, (k == 5) ? E_REL : E_WAIT, "b2b_fall");
    step(1'b0, OP_ADDI, 1'b0, E_ADDI, "b2b_back_run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
